// File: rtl/modulo_n_stream.sv
// -----------------------------------------------------------------------------
// modulo_n_stream
//
// Running residue of an MSB-first number streamed IN_W bits per beat, taken
// modulo a modulus N that is loaded at frame start. Each frame has a
// programmable length in beats and uses a start/valid/ready/done handshake.
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   reset    - asynchronous, active-low reset
//   start_i  - frame start, only looked at while idle
//   mod_n_i  - modulus N, captured when the start is accepted
//   len_i    - beats in the frame, captured when the start is accepted
//   val_i    - data beat, MSB first
//   valid_i  - beat valid
//   abort_i  - abandon the frame in progress
//   ready_o  - high while a frame is running; beat taken on valid_i & ready_o
//   mod      - running residue, then the final residue
//   done_o   - one-cycle pulse when a frame completes
//   err_o    - set when a frame was started with N == 0, cleared by next start
//   busy_o   - high while a frame is running or completing
// -----------------------------------------------------------------------------
module modulo_n_stream #(
    parameter int MOD_W = 4,
    parameter int IN_W  = 1,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [MOD_W-1:0] mod_n_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [IN_W-1:0]  val_i,
    input  logic             valid_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic [MOD_W-1:0] mod,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_reg;
    logic [MOD_W-1:0] n_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] count_reg;
    logic [MOD_W-1:0] mod_reg;
    logic             err_reg;
    logic [MOD_W-1:0] mod_next;

    // Reduction chain: one shift-and-conditional-subtract per input bit,
    // MSB first. Because every stage output is < N, 2r+bit <= 2N-1 and fits
    // in MOD_W+1 bits; the difference itself is < N so MOD_W bits suffice.
    logic [MOD_W-1:0] step_r [0:IN_W];

    assign step_r[0] = mod_reg;

    generate
        for (genvar gi = 0; gi < IN_W; gi++) begin : g_step
            logic [MOD_W:0]   shifted;
            logic [MOD_W-1:0] diff;
            logic             ge_n;

            assign shifted = {step_r[gi], val_i[IN_W-1-gi]};
            assign ge_n    = (shifted >= {1'b0, n_reg});
            assign diff    = shifted[MOD_W-1:0] - n_reg;
            assign step_r[gi+1] = ge_n ? diff : shifted[MOD_W-1:0];
        end
    endgenerate

    assign mod_next = step_r[IN_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            n_reg     <= '0;
            len_reg   <= '0;
            count_reg <= '0;
            mod_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        n_reg     <= mod_n_i;
                        len_reg   <= len_i;
                        mod_reg   <= '0;
                        count_reg <= '0;
                        err_reg   <= (mod_n_i == '0);
                        // Degenerate frames (no modulus or no beats) complete
                        // immediately without ever offering ready.
                        if (mod_n_i == '0 || len_i == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort wins over a beat presented in the same cycle.
                    if (abort_i) begin
                        state_reg <= ST_IDLE;
                    end else if (valid_i) begin
                        mod_reg <= mod_next;
                        if (count_reg == len_reg - LEN_ONE) begin
                            state_reg <= ST_DONE;
                        end else begin
                            count_reg <= count_reg + LEN_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state_reg == ST_RUN);
    assign done_o  = (state_reg == ST_DONE);
    assign busy_o  = (state_reg != ST_IDLE);
    assign mod     = mod_reg;
    assign err_o   = err_reg;

endmodule

// File: doc/modulo_n_stream.md
Name: modulo_n_stream

Overview:
Parametrised successor to the fixed modulo-5 serial residue block. It computes the running residue of an MSB-first number streamed IN_W bits per beat, modulo a runtime-loadable N. Frame length is programmable, and a start/valid/ready/done handshake wraps each computation. It sits in the parameterised-modules library as a reusable divisibility/checksum primitive for serial datapaths.

Parameters:
MOD_W, 4, width of modulus and residue; N ranges 1..2^MOD_W-1.
IN_W, 1, bits consumed per accepted beat, MSB-first within the beat.
LEN_W, 8, width of the frame-length field (beats per frame).

Ports:
clk  input  1  clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset.
start_i  input  1  frame start; sampled only in IDLE.
mod_n_i  input  MOD_W  modulus N, latched on accepted start.
len_i  input  LEN_W  beats in frame, latched on accepted start.
val_i  input  IN_W  data beat, MSB-first.
valid_i  input  1  beat valid.
abort_i  input  1  abandon current frame.
ready_o  output  1  high in RUN; beat accepted when valid_i & ready_o.
mod  output  MOD_W  running/final residue.
done_o  output  1  one-cycle pulse, frame complete.
err_o  output  1  latched N==0 error, cleared by next accepted start.
busy_o  output  1  high in RUN or DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mod=0, done_o=0, err_o=0, ready_o=0, busy_o=0; internal N, count and length cleared. Asserting reset mid-frame discards the frame with no done_o.
- States: IDLE, RUN, DONE.
- IDLE, start_i=1 (accepted start):
  - latch N and len; mod<=0; count<=0; err_o<=0.
  - If mod_n_i==0: err_o<=1, go to DONE.
  - Else if len_i==0: go to DONE.
  - Else go to RUN.
- IDLE, start_i=0: mod holds its last value.
- RUN, ready_o=1. Accepted beat: mod <= (mod*2^IN_W + val_i) mod N, visible the cycle after acceptance.
  - Reduction is IN_W unrolled steps, MSB-first: r=2r+bit; if r>=N then r=r-N.
  - Intermediate width is MOD_W+1. Result is always < N.
  - Single-cycle throughput: one beat per clock.
- RUN, valid_i=0: mod and count hold. Gaps are allowed anywhere in the frame.
- Last beat: when count reaches len-1 and a beat is accepted, go to DONE. ready_o drops the next cycle.
- DONE: lasts exactly one cycle. done_o=1, busy_o=1, ready_o=0, mod holds the final residue. Then go to IDLE.
- Ignored inputs:
  - start_i outside IDLE.
  - valid_i outside RUN.
  - mod_n_i and len_i changes after the start is accepted.
- abort_i in RUN: go to IDLE next cycle, no done_o, mod holds its partial value. abort_i has priority over a simultaneous beat, which is not accepted. abort_i in IDLE or DONE has no effect.
- N==1: mod stays 0 for every beat.
- Count is LEN_W bits and never wraps: len ≤ 2^LEN_W-1.

Test Plan:
1. IN_W=1, N=5, len=6, bits 1,0,1,1,0,1 back-to-back (=45) -> mod 1,2,0,1,2,0; done_o pulses the cycle after the 6th beat with mod=0.
2. IN_W=2, N=7, len=3, beats 3,2,1 (=57) -> mod 3,0,1; done_o with mod=1; ready_o low in DONE.
3. N=5, len=4, bits 1,1,1,1 with valid_i low for 2 cycles between each beat -> mod holds during gaps; sequence 1,3,2,0; exactly one done_o.
4. start with mod_n_i=0 -> next cycle DONE: done_o=1, err_o=1, mod=0. Next start with N=3 clears err_o.
5. start with len_i=0, N=5 -> done_o the cycle after start, mod=0, ready_o never high.
6. Mid-frame (N=5, bits 1,0 accepted, mod=2): abort_i with valid_i=1 -> beat not accepted, IDLE, no done_o, mod=2. Repeat the run with reset=0 asynchronously mid-frame -> all outputs 0 immediately.
